// File: rtl/host_loader_pkg.sv
// host_loader_pkg: loader FSM states, link handshake bytes and a byte-select helper.
package host_loader_pkg;
   typedef enum logic [2:0] {IDLE, WAIT_99, SEND_SIZE, FETCH, SEND_WORD, WAIT_AA, RUN} state_t;
   localparam logic [7:0] SYNC_BYTE = 8'h99;
   localparam logic [7:0] RUN_BYTE  = 8'hAA;
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
      return w[{i, 3'b000} +: 8];
   endfunction
endpackage

// File: rtl/host_loader.sv
// host_loader: streams a program image to the CPU link after a 0x99 handshake,
// then bridges host stdin/stdout to the link once the CPU answers 0xAA.
module host_loader
   import host_loader_pkg::*;
#(
   parameter int WORD_ADDR_BITWIDTH = 14
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic [WORD_ADDR_BITWIDTH:0]   prog_word_count,
   output logic [WORD_ADDR_BITWIDTH-1:0] prog_read_address,
   input  logic [31:0]                   prog_read_data,
   input  logic                          rx_valid,
   input  logic [7:0]                    rx_data,
   output logic                          tx_valid,
   output logic [7:0]                    tx_data,
   input  logic                          tx_ready,
   input  logic                          stdin_valid,
   input  logic [7:0]                    stdin_data,
   output logic                          stdin_ready,
   output logic                          stdout_valid,
   output logic [7:0]                    stdout_data,
   output logic                          busy,
   output logic                          running,
   output logic                          protocol_error
);
   localparam int W = WORD_ADDR_BITWIDTH;
   state_t state, state_next;
   logic [W:0]   count;
   logic [W-1:0] addr;
   logic [1:0]   byte_cnt;
   logic [31:0]  word, size;
   logic         last, at_last, sending;
   assign size              = 32'(count) << 2;
   assign at_last           = {1'b0, addr} == count - 1'b1;
   assign sending           = state == SEND_SIZE || state == SEND_WORD;
   assign prog_read_address = addr;
   assign busy              = state != IDLE && state != RUN;
   assign running           = state == RUN;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= IDLE;
      else state <= state_next;
   always_comb begin
      state_next  = state;
      tx_valid    = 1'b0;
      tx_data     = 8'h00;
      stdin_ready = 1'b0;
      case (state)
         IDLE:      state_next = start ? WAIT_99 : IDLE;
         WAIT_99:   state_next = (rx_valid && rx_data == SYNC_BYTE) ? SEND_SIZE : WAIT_99;
         SEND_SIZE: begin
            tx_valid = 1'b1;
            tx_data  = byte_of(size, byte_cnt);
            if (tx_ready && byte_cnt == 2'd3) state_next = (count == '0) ? WAIT_AA : FETCH;
         end
         FETCH:     state_next = SEND_WORD;
         SEND_WORD: begin
            tx_valid = 1'b1;
            tx_data  = byte_of(word, byte_cnt);
            if (tx_ready && byte_cnt == 2'd3) state_next = last ? WAIT_AA : FETCH;
         end
         WAIT_AA:   state_next = (rx_valid && rx_data == RUN_BYTE) ? RUN : WAIT_AA;
         RUN: begin
            tx_valid    = stdin_valid;
            tx_data     = stdin_data;
            stdin_ready = tx_ready;
         end
         default:   state_next = IDLE;
      endcase
   end
   // The address advances as soon as a word is latched, so the next word is already
   // settled on prog_read_data long before its single FETCH cycle.
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         count          <= '0;
         addr           <= '0;
         byte_cnt       <= 2'd0;
         word           <= 32'h0;
         last           <= 1'b0;
         protocol_error <= 1'b0;
         stdout_valid   <= 1'b0;
         stdout_data    <= 8'h00;
      end else begin
         if (state == IDLE && start) count <= prog_word_count;
         if (state == SEND_SIZE) addr <= '0;
         if (sending && tx_ready) byte_cnt <= byte_cnt + 2'd1;
         if (state == FETCH) begin
            word <= prog_read_data;
            last <= at_last;
            if (!at_last) addr <= addr + 1'b1;
         end
         if (rx_valid && (state inside {SEND_SIZE, FETCH, SEND_WORD} ||
                          (state == WAIT_AA && rx_data != RUN_BYTE)))
            protocol_error <= 1'b1;
         stdout_valid <= state == RUN && rx_valid;
         if (state == RUN && rx_valid) stdout_data <= rx_data;
      end
endmodule

// File: doc/host_loader.md
HOST_LOADER -- requirements
Module: host_loader

Interface
REQ-001 Parameter WORD_ADDR_BITWIDTH, default 14, width of the program-image word address.
REQ-002 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 Port reset_n  input  1  asynchronous, active-low reset.
REQ-004 Port start  input  1  one-cycle pulse; arms a load session from IDLE.
REQ-005 Port prog_word_count  input  WORD_ADDR_BITWIDTH+1  number of 32-bit program words; sampled on start.
REQ-006 Port prog_read_address  output  WORD_ADDR_BITWIDTH  word address into the host-side image memory.
REQ-007 Port prog_read_data  input  32  image word; valid exactly 1 cycle after the address is presented (synchronous read).
REQ-008 Port rx_valid, rx_data  input  1, 8  received-byte pulse and byte from the CPU link; no backpressure.
REQ-009 Port tx_valid, tx_data, tx_ready  output, output, input  1, 8, 1  byte stream to the link transmitter.
REQ-010 Port stdin_valid, stdin_data, stdin_ready  input, input, output  1, 8, 1  host stdin byte stream.
REQ-011 Port stdout_valid, stdout_data  output  1, 8  one-cycle pulse carrying each CPU output byte.
REQ-012 Port busy, running, protocol_error  output  1 each  status flags.

Function
REQ-013 The FSM SHALL have states IDLE, WAIT_99, SEND_SIZE, FETCH, SEND_WORD, WAIT_AA, RUN.
REQ-014 IDLE->WAIT_99 on start; start SHALL be ignored in every other state.
REQ-015 WAIT_99 SHALL discard all rx bytes other than 0x99; on rx 0x99 it SHALL go to SEND_SIZE.
REQ-016 SEND_SIZE SHALL transmit the byte count (prog_word_count*4, 32 bits) as 4 bytes, least significant byte first.
REQ-017 A byte transfer SHALL complete only in a cycle with tx_valid&&tx_ready; tx_data SHALL be held stable while tx_valid&&!tx_ready.
REQ-018 After the 4th size byte, a word count of 0 SHALL go directly to WAIT_AA; otherwise the FSM SHALL go to FETCH at address 0.
REQ-019 FETCH SHALL last exactly 1 cycle; the FSM then SHALL latch prog_read_data and enter SEND_WORD.
REQ-020 SEND_WORD SHALL transmit the latched word as 4 bytes, LSB first, then increment the address and return to FETCH, or go to WAIT_AA after the last word.
REQ-021 tx_valid SHALL be 0 in IDLE, WAIT_99, FETCH, WAIT_AA, and 1 throughout SEND_SIZE and SEND_WORD.
REQ-022 In WAIT_AA, rx 0xAA SHALL enter RUN; any other rx byte SHALL set protocol_error (sticky until reset) and be dropped.
REQ-023 rx bytes received in SEND_SIZE, FETCH or SEND_WORD SHALL set protocol_error and be dropped.
REQ-024 RUN SHALL drive tx_valid=stdin_valid, tx_data=stdin_data, stdin_ready=tx_ready (combinational pass-through, zero latency).
REQ-025 stdin_ready SHALL be 0 in all states except RUN.
REQ-026 In RUN, each rx_valid SHALL produce stdout_valid=1 with stdout_data=rx_data on the next cycle (1-cycle registered latency).
REQ-027 In every state other than RUN, stdout_valid SHALL be 0.
REQ-028 RUN SHALL persist until reset.
REQ-029 busy SHALL be 1 in all states other than IDLE and RUN; running SHALL be 1 only in RUN.
REQ-030 The byte counter SHALL be 2 bits and wrap 3->0 at each word boundary; the word address SHALL not increment past prog_word_count-1.

Reset
REQ-031 While reset_n=0 (asynchronously asserted), the state SHALL be IDLE and all outputs SHALL be 0, including tx_valid, stdout_valid, protocol_error, prog_read_address and the counters.
REQ-032 Reset asserted mid-transfer SHALL abort immediately with no further tx byte; after release the FSM SHALL wait for a new start.

Structure
REQ-033 State enum and the constants 0x99 and 0xAA SHALL live in the shared define package with the other UART protocol constants.
REQ-034 No sub-module is required; the UART byte transmitter and receiver SHALL be instantiated outside this block.

Verification
REQ-035 Count=2, image {0x11223344,0xAABBCCDD}, rx 0x99, tx_ready=1 -> tx 08 00 00 00 44 33 22 11 DD CC BB AA, then WAIT_AA.
REQ-036 Same stimulus with tx_ready toggling every cycle -> identical byte sequence; tx_data stable while stalled.
REQ-037 Count=0 -> tx 00 00 00 00, no prog reads, busy=1 until rx 0xAA, then running=1.
REQ-038 rx 0x55 in WAIT_99 -> ignored, no error; rx 0x55 in WAIT_AA -> protocol_error=1, still in WAIT_AA; 0xAA -> RUN.
REQ-039 In RUN: stdin 0x41 with tx_ready=1 -> tx 0x41 same cycle; rx 0x7A -> stdout_valid with 0x7A the next cycle.
REQ-040 reset_n pulsed low during the 3rd byte of word 0 -> all outputs 0 immediately; a new start plus rx 0x99 restarts from the size bytes.
